// File: rtl/apex_meta_pkg.sv
// Shared register-window layout for the APEX metadata block.
// Offsets are byte offsets from the window base.
package apex_meta_pkg;

    localparam int          DATA_W         = 16;

    localparam logic [15:0] OFF_ER_MIN     = 16'h0000;
    localparam logic [15:0] OFF_ER_MAX     = 16'h0002;
    localparam logic [15:0] OFF_OR_MIN     = 16'h0004;
    localparam logic [15:0] OFF_OR_MAX     = 16'h0006;
    localparam logic [15:0] OFF_STATUS     = 16'h0008;
    localparam logic [15:0] OFF_RUN_CNT    = 16'h000A;
    localparam logic [15:0] OFF_VIOL_CNT   = 16'h000C;
    localparam logic [15:0] META_SIZE      = 16'h000E;

    localparam int          STATUS_CLR_BIT = 15;

endpackage

// File: rtl/apex_evt_cnt.sv
// Rising-edge event counter: saturates at all-ones, synchronous clear has priority.
module apex_evt_cnt
    import apex_meta_pkg::*;
(
    input  logic              clk,
    input  logic              puc,
    input  logic              evt,
    input  logic              clr,
    output logic [DATA_W-1:0] cnt
);

    logic              evt_q;
    logic [DATA_W-1:0] cnt_q;
    logic              evt_rise;

    function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] v);
        return (v == {DATA_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    assign evt_rise = evt && !evt_q;

    always_ff @(posedge clk) begin
        if (puc) begin
            evt_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            evt_q <= evt;
            if (clr)
                cnt_q <= '0;
            else if (evt_rise)
                cnt_q <= sat_inc(cnt_q);
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/apex_meta_regs.sv
// Memory-mapped APEX metadata registers: ER/OR region bounds, status and
// execution/violation event counters, read data returned one cycle after request.
module apex_meta_regs
    import apex_meta_pkg::*;
#(
    parameter logic [15:0] META_BASE  = 16'h0140,
    parameter logic [15:0] ER_MIN_RST = 16'hE000,
    parameter logic [15:0] ER_MAX_RST = 16'hE000,
    parameter logic [15:0] OR_MIN_RST = 16'hF000,
    parameter logic [15:0] OR_MAX_RST = 16'hF000
) (
    input  logic              clk,
    input  logic              puc,
    input  logic              data_en,
    input  logic [1:0]        data_we,
    input  logic [15:0]       data_addr,
    input  logic [DATA_W-1:0] data_din,
    output logic [DATA_W-1:0] data_dout,
    input  logic              exec,
    input  logic              reset,
    output logic [DATA_W-1:0] ER_min,
    output logic [DATA_W-1:0] ER_max,
    output logic [DATA_W-1:0] OR_min,
    output logic [DATA_W-1:0] OR_max
);

    logic [15:0]       off;
    logic [15:0]       word_off;
    logic              hit;
    logic              rd_req;
    logic              wr_req;
    logic              cnt_clr;
    logic [DATA_W-1:0] er_min_q, er_max_q, or_min_q, or_max_q;
    logic [DATA_W-1:0] run_cnt, viol_cnt;
    logic [DATA_W-1:0] rd_mux;
    logic [DATA_W-1:0] rd_data_p1;

    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old_v,
        input logic [DATA_W-1:0] new_v,
        input logic [1:0]        be
    );
        return {be[1] ? new_v[15:8] : old_v[15:8],
                be[0] ? new_v[7:0]  : old_v[7:0]};
    endfunction

    // Odd byte addresses fold onto their word; anything outside the window is unselected.
    assign off      = data_addr - META_BASE;
    assign word_off = off & ~16'h0001;
    assign hit      = data_en && (data_addr >= META_BASE) && (off < META_SIZE);
    assign rd_req   = hit && (data_we == 2'b00);
    assign wr_req   = hit && (data_we != 2'b00);
    assign cnt_clr  = wr_req && (word_off == OFF_STATUS) && data_we[1] && data_din[STATUS_CLR_BIT];

    always_ff @(posedge clk) begin
        if (puc) begin
            er_min_q <= ER_MIN_RST;
            er_max_q <= ER_MAX_RST;
            or_min_q <= OR_MIN_RST;
            or_max_q <= OR_MAX_RST;
        end else if (wr_req) begin
            case (word_off)
                OFF_ER_MIN: er_min_q <= merge_bytes(er_min_q, data_din, data_we);
                OFF_ER_MAX: er_max_q <= merge_bytes(er_max_q, data_din, data_we);
                OFF_OR_MIN: or_min_q <= merge_bytes(or_min_q, data_din, data_we);
                OFF_OR_MAX: or_max_q <= merge_bytes(or_max_q, data_din, data_we);
                default:    ;
            endcase
        end
    end

    apex_evt_cnt u_run_cnt (
        .clk (clk),
        .puc (puc),
        .evt (exec),
        .clr (cnt_clr),
        .cnt (run_cnt)
    );

    apex_evt_cnt u_viol_cnt (
        .clk (clk),
        .puc (puc),
        .evt (reset),
        .clr (cnt_clr),
        .cnt (viol_cnt)
    );

    always_comb begin
        rd_mux = '0;
        case (word_off)
            OFF_ER_MIN:   rd_mux = er_min_q;
            OFF_ER_MAX:   rd_mux = er_max_q;
            OFF_OR_MIN:   rd_mux = or_min_q;
            OFF_OR_MAX:   rd_mux = or_max_q;
            OFF_STATUS:   rd_mux = {14'b0, reset, exec};
            OFF_RUN_CNT:  rd_mux = run_cnt;
            OFF_VIOL_CNT: rd_mux = viol_cnt;
            default:      rd_mux = '0;
        endcase
    end

    // Stage p1: registered read data, zero in every cycle without a read.
    always_ff @(posedge clk) begin
        if (puc)
            rd_data_p1 <= '0;
        else
            rd_data_p1 <= rd_req ? rd_mux : '0;
    end

    assign data_dout = rd_data_p1;
    assign ER_min    = er_min_q;
    assign ER_max    = er_max_q;
    assign OR_min    = or_min_q;
    assign OR_max    = or_max_q;

endmodule

// File: tb/tb_apex_meta_regs.sv
// Bench for apex_meta_regs: behavioural register-window model checked every cycle,
// plus directed reads with literal expected values.
module tb_apex_meta_regs;

    localparam logic [15:0] BASE = 16'h0140;

    logic        clk = 1'b0;
    logic        puc;
    logic        data_en;
    logic [1:0]  data_we;
    logic [15:0] data_addr;
    logic [15:0] data_din;
    logic [15:0] data_dout;
    logic        exec;
    logic        reset;
    logic [15:0] ER_min, ER_max, OR_min, OR_max;

    int n_checks = 0;
    int n_fail   = 0;

    apex_meta_regs dut (
        .clk       (clk),
        .puc       (puc),
        .data_en   (data_en),
        .data_we   (data_we),
        .data_addr (data_addr),
        .data_din  (data_din),
        .data_dout (data_dout),
        .exec      (exec),
        .reset     (reset),
        .ER_min    (ER_min),
        .ER_max    (ER_max),
        .OR_min    (OR_min),
        .OR_max    (OR_max)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: four bound registers, two counters, previous flag values, expected dout.
    logic [15:0] m_reg [4];
    logic [15:0] m_run, m_viol, m_dout;
    logic        m_pe, m_pr;
    bit          m_ok = 0;

    always @(posedge clk) begin
        int  o;
        bit  in_win, clr;
        if (puc) begin
            m_reg[0] = 16'hE000; m_reg[1] = 16'hE000;
            m_reg[2] = 16'hF000; m_reg[3] = 16'hF000;
            m_run = 0; m_viol = 0; m_pe = 0; m_pr = 0; m_dout = 0;
            m_ok = 1;
        end else begin
            o      = int'(data_addr) - int'(BASE);
            in_win = data_en && (o >= 0) && (o < 14);
            o      = (o / 2) * 2;
            m_dout = 16'h0000;
            if (in_win && data_we == 2'b00) begin
                if (o < 8)        m_dout = m_reg[o/2];
                else if (o == 8)  m_dout = {14'b0, reset, exec};
                else if (o == 10) m_dout = m_run;
                else              m_dout = m_viol;
            end
            clr = in_win && (data_we[1] == 1'b1) && (o == 8) && data_din[15];
            if (in_win && data_we != 2'b00 && o < 8) begin
                if (data_we[0]) m_reg[o/2][7:0]  = data_din[7:0];
                if (data_we[1]) m_reg[o/2][15:8] = data_din[15:8];
            end
            if (clr) m_run = 0;
            else if (exec && !m_pe && m_run != 16'hFFFF) m_run = m_run + 1;
            if (clr) m_viol = 0;
            else if (reset && !m_pr && m_viol != 16'hFFFF) m_viol = m_viol + 1;
            m_pe = exec;
            m_pr = reset;
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            check("model_dout",   data_dout, m_dout);
            check("model_ER_min", ER_min,    m_reg[0]);
            check("model_ER_max", ER_max,    m_reg[1]);
            check("model_OR_min", OR_min,    m_reg[2]);
            check("model_OR_max", OR_max,    m_reg[3]);
        end
    end

    // All tasks are entered 1 time unit after a rising edge and return aligned the same way.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [15:0] o, input logic [1:0] we, input logic [15:0] d);
        data_en = 1; data_we = we; data_addr = BASE + o; data_din = d;
        tick(1);
        data_en = 0; data_we = 2'b00; data_din = 16'h0000;
    endtask

    task automatic rd(input logic [15:0] o, input logic [15:0] exp, input string nm);
        data_en = 1; data_we = 2'b00; data_addr = BASE + o;
        tick(1);
        data_en = 0;
        @(negedge clk);
        check(nm, data_dout, exp);
        tick(1);
    endtask

    task automatic pulse_exec();
        exec = 1; tick(1); exec = 0; tick(1);
    endtask

    task automatic pulse_reset();
        reset = 1; tick(1); reset = 0; tick(1);
    endtask

    initial begin
        puc = 1; data_en = 0; data_we = 0; data_addr = 0; data_din = 0; exec = 0; reset = 0;
        repeat (3) @(posedge clk);
        #1 puc = 0;

        rd(16'h0, 16'hE000, "rst_er_min");
        rd(16'h2, 16'hE000, "rst_er_max");
        rd(16'h4, 16'hF000, "rst_or_min");
        rd(16'h6, 16'hF000, "rst_or_max");
        rd(16'h8, 16'h0000, "rst_status");
        rd(16'hA, 16'h0000, "rst_run");
        rd(16'hC, 16'h0000, "rst_viol");
        check("idle_dout", data_dout, 16'h0000);

        wr(16'h0, 2'b01, 16'hE1CC);
        check("er_min_lowbyte", ER_min, 16'hE0CC);
        wr(16'h0, 2'b11, 16'hE1CC);
        check("er_min_word", ER_min, 16'hE1CC);
        wr(16'h2, 2'b10, 16'h12AB);
        check("er_max_highbyte", ER_max, 16'h1200);
        wr(16'h4, 2'b11, 16'h0100);
        wr(16'h6, 2'b11, 16'h0050);
        rd(16'h5, 16'h0100, "or_min_odd_addr");
        rd(16'h6, 16'h0050, "or_max_below_min");
        data_en = 1; data_we = 2'b11; data_addr = BASE - 2; data_din = 16'h5555;
        tick(1);
        data_en = 0; data_we = 2'b00;
        rd(16'h0, 16'hE1CC, "outside_write_ignored");

        pulse_exec(); pulse_exec(); pulse_exec();
        pulse_reset(); pulse_reset();
        rd(16'hA, 16'h0003, "run_three");
        rd(16'hC, 16'h0002, "viol_two");
        exec = 1;
        tick(2);
        rd(16'h8, 16'h0001, "status_exec");
        tick(6);
        exec = 0;
        tick(1);
        rd(16'hA, 16'h0004, "run_held_one_edge");

        exec = 1;
        rd(16'hA, 16'h0004, "read_pre_increment");
        exec = 0;
        rd(16'hA, 16'h0005, "run_after_inc");

        wr(16'hA, 2'b11, 16'h1234);
        wr(16'hC, 2'b11, 16'h1234);
        wr(16'h8, 2'b01, 16'h8000);
        wr(16'h8, 2'b11, 16'h7FFF);
        rd(16'hA, 16'h0005, "run_ro");
        rd(16'hC, 16'h0002, "viol_ro");

        exec = 1;
        wr(16'h8, 2'b11, 16'h8000);
        exec = 0;
        tick(1);
        rd(16'hA, 16'h0000, "clear_beats_edge");
        rd(16'hC, 16'h0000, "viol_cleared");

        force dut.u_run_cnt.cnt_q = 16'hFFFE;
        m_run = 16'hFFFE;
        tick(1);
        release dut.u_run_cnt.cnt_q;
        tick(1);
        pulse_exec();
        rd(16'hA, 16'hFFFF, "run_reach_max");
        pulse_exec();
        rd(16'hA, 16'hFFFF, "run_saturated");

        wr(16'hA, 2'b11, 16'h1234);
        rd(16'hA, 16'hFFFF, "run_write_ignored");
        puc = 1; exec = 1; reset = 1;
        data_en = 1; data_we = 2'b11; data_addr = BASE; data_din = 16'h1234;
        tick(2);
        puc = 0; reset = 0;
        data_en = 0; data_we = 2'b00; data_din = 16'h0000;
        tick(1);
        exec = 0;
        check("post_puc_er_min", ER_min, 16'hE000);
        check("post_puc_er_max", ER_max, 16'hE000);
        check("post_puc_or_min", OR_min, 16'hF000);
        check("post_puc_or_max", OR_max, 16'hF000);
        rd(16'hA, 16'h0001, "exec_after_puc");
        rd(16'hC, 16'h0000, "viol_after_puc");
        tick(3);
        check("idle_dout_end", data_dout, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/apex_meta_regs.md
APEX_META_REGS -- requirements
Module: apex_meta_regs

Interface
REQ-001 SHALL have parameter META_BASE, default 16'h0140, giving the byte base address of the register window.
REQ-002 SHALL have parameter ER_MIN_RST, default 16'hE000, giving the ER_min reset value.
REQ-003 SHALL have parameter ER_MAX_RST, default 16'hE000, giving the ER_max reset value.
REQ-004 SHALL have parameter OR_MIN_RST, default 16'hF000, giving the OR_min reset value.
REQ-005 SHALL have parameter OR_MAX_RST, default 16'hF000, giving the OR_max reset value.
REQ-006 SHALL have ports, in this order:
- clk  in  1  system clock; one clock, all state on rising edge.
- puc  in  1  reset; synchronous, active-high.
- data_en  in  1  CPU data access strobe.
- data_we  in  2  byte write enables: [0] low byte, [1] high byte; 0 means read.
- data_addr  in  16  byte address; bit 0 ignored.
- data_din  in  16  write data.
- data_dout  out  16  read data; 0 when not selected.
- exec  in  1  VAPE execution-proof flag from hwmod.
- reset  in  1  VRASED violation reset from hwmod.
- ER_min, ER_max, OR_min, OR_max  out  16 each  region bounds feeding hwmod.

Function
REQ-007 Window offsets from META_BASE SHALL be: +0 ER_min, +2 ER_max, +4 OR_min, +6 OR_max (all RW); +8 STATUS; +A RUN_CNT (RO); +C VIOL_CNT (RO). Other addresses are not selected.
REQ-008 A write (data_en=1, data_we!=0, address hit) SHALL update only the enabled bytes, with the new value visible on the outputs the next cycle.
REQ-009 Writes to RUN_CNT, VIOL_CNT and unmapped offsets SHALL be ignored.
REQ-010 A read (data_en=1, data_we=0, address hit) SHALL drive data_dout with the addressed value exactly one cycle later; data_dout SHALL be 16'h0000 in every other cycle.
REQ-011 STATUS read SHALL return {14'b0, reset, exec}, sampled in the cycle the read is issued.
REQ-012 A STATUS write with data_we[1]=1 and data_din[15]=1 SHALL clear RUN_CNT and VIOL_CNT the next cycle; other STATUS bits SHALL be ignored.
REQ-013 RUN_CNT SHALL increment by 1 on each exec 0->1 edge, comparing exec with a registered copy that resets to 0.
REQ-014 VIOL_CNT SHALL increment by 1 on each reset 0->1 edge, using the same edge-detect scheme.
REQ-015 Both counters SHALL be 16-bit and saturate at 16'hFFFF (no wrap).
REQ-016 Clear and an edge in the same cycle: the clear SHALL win, and the counter SHALL be 0 next cycle.
REQ-017 A read and an increment in the same cycle: the read SHALL return the pre-increment value.
REQ-018 ER/OR registers SHALL NOT be range-checked here (ER_min>ER_max is legal); policy enforcement belongs to hwmod.

Reset
REQ-019 While puc=1 at a clock edge: ER_min=ER_MIN_RST, ER_max=ER_MAX_RST, OR_min=OR_MIN_RST, OR_max=OR_MAX_RST; both counters 0; edge-detect registers 0; read-data register 0.
REQ-020 While puc=1, bus writes and counter increments SHALL be ignored.
REQ-021 If exec=1 in the first cycle after puc falls, RUN_CNT SHALL count one edge.

Structure
REQ-022 Offsets, the window size (16'h000E) and the clear-bit index SHALL live in the shared package apex_meta_pkg; reset values remain parameters.
REQ-023 The edge-detect plus saturating counter with synchronous clear SHALL be the sub-module apex_evt_cnt, instantiated twice.

Verification
REQ-024 puc pulse, then read all seven offsets -> E000, E000, F000, F000, 0000, 0000, 0000, each one cycle after its request.
REQ-025 Write 16'hE1CC to +0 with data_we=2'b01 -> ER_min=16'hE0CC the next cycle; a word write of 16'hE1CC -> ER_min=16'hE1CC.
REQ-026 Drive 3 exec pulses and 2 reset pulses -> RUN_CNT=3, VIOL_CNT=2; an exec held high for 10 cycles counts as one edge.
REQ-027 Preload RUN_CNT to FFFF via 65535 edges (or force), then one more edge -> stays FFFF.
REQ-028 STATUS write 16'h8000 in the same cycle as an exec edge -> RUN_CNT=0 next cycle.
REQ-029 Write to +A, then puc mid-sequence -> RUN_CNT unchanged by the write; all registers at reset values after puc; data_dout=0 when idle.
